// File: rtl/tmds_pkg.sv
// Shared TMDS symbol constants, receive-state encoding and the video-data decode function.
package tmds_pkg;

    localparam logic [9:0] CTRL_TOKEN_00 = 10'h354;
    localparam logic [9:0] CTRL_TOKEN_01 = 10'h0AB;
    localparam logic [9:0] CTRL_TOKEN_10 = 10'h154;
    localparam logic [9:0] CTRL_TOKEN_11 = 10'h2AB;

    // Index is the decoded nibble.
    localparam logic [9:0] TERC4_TABLE [16] = '{
        10'h29C, 10'h263, 10'h2E4, 10'h2E2, 10'h171, 10'h11E, 10'h18E, 10'h13C,
        10'h2CC, 10'h139, 10'h19C, 10'h2C6, 10'h28E, 10'h271, 10'h163, 10'h2C3
    };

    typedef enum logic [0:0] {
        StSearch,
        StLocked
    } rx_state_e;

    function automatic logic [7:0] tmds_decode_data(input logic [9:0] sym);
        logic [7:0] q;
        logic [7:0] d;
        q    = sym[9] ? ~sym[7:0] : sym[7:0];
        d[0] = q[0];
        for (int i = 1; i < 8; i++) begin
            d[i] = sym[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
        end
        return d;
    endfunction

endpackage

// File: rtl/tmds_symbol_decode.sv
// Purely combinational classification and decode of one 10-bit TMDS symbol.
module tmds_symbol_decode
    import tmds_pkg::*;
(
    input  logic [9:0] sym,
    output logic [7:0] data,
    output logic       ctrl_valid,
    output logic [1:0] ctrl,
    output logic       terc4_valid,
    output logic [3:0] terc4
);

    always_comb begin
        data        = tmds_decode_data(sym);
        ctrl_valid  = 1'b1;
        ctrl        = 2'b00;
        terc4_valid = 1'b0;
        terc4       = 4'd0;

        case (sym)
            CTRL_TOKEN_00: ctrl = 2'b00;
            CTRL_TOKEN_01: ctrl = 2'b01;
            CTRL_TOKEN_10: ctrl = 2'b10;
            CTRL_TOKEN_11: ctrl = 2'b11;
            default:       ctrl_valid = 1'b0;
        endcase

        for (int i = 0; i < 16; i++) begin
            if (sym == TERC4_TABLE[i]) begin
                terc4_valid = 1'b1;
                terc4       = 4'(i);
            end
        end
    end

endmodule

// File: rtl/tmds_rx_channel.sv
// One TMDS receive channel: bit-slip word alignment against control tokens plus registered
// symbol decode.
module tmds_rx_channel
    import tmds_pkg::*;
#(
    parameter int unsigned CTRL_RUN      = 8,
    parameter int unsigned SEARCH_CYCLES = 4096,
    parameter int unsigned LOSS_CYCLES   = 4096
) (
    input  logic       clk_pixel,
    input  logic       reset_n,
    input  logic [9:0] raw_in,
    output logic       locked,
    output logic [3:0] offset,
    output logic [7:0] data,
    output logic       ctrl_valid,
    output logic [1:0] ctrl,
    output logic       terc4_valid,
    output logic [3:0] terc4
);

    localparam int unsigned RunW    = (CTRL_RUN > 2) ? $clog2(CTRL_RUN) : 1;
    localparam int unsigned SearchW = (SEARCH_CYCLES > 2) ? $clog2(SEARCH_CYCLES) : 1;
    localparam int unsigned LossW   = (LOSS_CYCLES > 2) ? $clog2(LOSS_CYCLES) : 1;
    localparam int unsigned TmrW    = (SearchW > LossW) ? SearchW : LossW;

    rx_state_e         state_q, state_d;
    logic [9:0]        prev_q, sym_q;
    logic [19:0]       combined;
    logic [3:0]        offset_q, offset_d;
    logic [RunW-1:0]   run_q, run_d;
    logic [TmrW-1:0]   tmr_q, tmr_d;
    logic [1:0]        hold_q, hold_d;

    logic [7:0]        dec_data;
    logic              dec_ctrl_valid;
    logic [1:0]        dec_ctrl;
    logic              dec_terc4_valid;
    logic [3:0]        dec_terc4;

    assign combined = {raw_in, prev_q};
    assign locked   = (state_q == StLocked);
    assign offset   = offset_q;

    tmds_symbol_decode u_decode (
        .sym         (sym_q),
        .data        (dec_data),
        .ctrl_valid  (dec_ctrl_valid),
        .ctrl        (dec_ctrl),
        .terc4_valid (dec_terc4_valid),
        .terc4       (dec_terc4)
    );

    // Alignment runs off the registered ctrl_valid, so hold_q masks the two stale symbols
    // still in flight after a slip.
    always_comb begin
        state_d  = state_q;
        offset_d = offset_q;
        run_d    = run_q;
        tmr_d    = tmr_q;
        hold_d   = hold_q;

        unique case (state_q)
            StSearch: begin
                tmr_d = tmr_q + 1'b1;
                if (hold_q != 2'd0) begin
                    run_d  = '0;
                    hold_d = hold_q - 1'b1;
                end else if (ctrl_valid) begin
                    run_d = run_q + 1'b1;
                end else begin
                    run_d = '0;
                end

                if (hold_q == 2'd0 && ctrl_valid && run_q == RunW'(CTRL_RUN - 1)) begin
                    state_d = StLocked;
                    run_d   = '0;
                    tmr_d   = '0;
                end else if (tmr_q == TmrW'(SEARCH_CYCLES - 1)) begin
                    offset_d = (offset_q == 4'd9) ? 4'd0 : offset_q + 4'd1;
                    run_d    = '0;
                    tmr_d    = '0;
                    hold_d   = 2'd2;
                end
            end
            StLocked: begin
                if (ctrl_valid) begin
                    tmr_d = '0;
                end else if (tmr_q == TmrW'(LOSS_CYCLES - 1)) begin
                    state_d = StSearch;
                    tmr_d   = '0;
                    run_d   = '0;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            default: state_d = StSearch;
        endcase
    end

    always_ff @(posedge clk_pixel) begin
        if (!reset_n) begin
            state_q     <= StSearch;
            prev_q      <= '0;
            sym_q       <= '0;
            offset_q    <= '0;
            run_q       <= '0;
            tmr_q       <= '0;
            hold_q      <= '0;
            data        <= '0;
            ctrl_valid  <= 1'b0;
            ctrl        <= '0;
            terc4_valid <= 1'b0;
            terc4       <= '0;
        end else begin
            state_q     <= state_d;
            prev_q      <= raw_in;
            sym_q       <= combined[offset_q +: 10];
            offset_q    <= offset_d;
            run_q       <= run_d;
            tmr_q       <= tmr_d;
            hold_q      <= hold_d;
            data        <= dec_data;
            ctrl_valid  <= dec_ctrl_valid;
            ctrl        <= dec_ctrl;
            terc4_valid <= dec_terc4_valid;
            terc4       <= dec_terc4;
        end
    end

endmodule

// File: tb/tb_tmds_rx_channel.sv
// Self-checking bench for tmds_rx_channel: directed scenarios plus random words, every cycle
// compared against a behavioural bit-window and lock model.
module tb_tmds_rx_channel;

    localparam int unsigned CTRL_RUN      = 8;
    localparam int unsigned SEARCH_CYCLES = 64;
    localparam int unsigned LOSS_CYCLES   = 128;

    localparam logic [9:0] T4 [16] = '{
        10'h29C, 10'h263, 10'h2E4, 10'h2E2, 10'h171, 10'h11E, 10'h18E, 10'h13C,
        10'h2CC, 10'h139, 10'h19C, 10'h2C6, 10'h28E, 10'h271, 10'h163, 10'h2C3
    };
    localparam logic [9:0] TOKS [4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};

    logic       clk_pixel = 1'b0;
    logic       reset_n;
    logic [9:0] raw_in;
    logic       locked;
    logic [3:0] offset;
    logic [7:0] data;
    logic       ctrl_valid;
    logic [1:0] ctrl;
    logic       terc4_valid;
    logic [3:0] terc4;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [9:0] m_prev, m_sym;
    int         m_off, m_run, m_cyc, m_blank, m_miss;
    bit         m_locked;
    logic [7:0] e_data;
    bit         e_cv, e_tv;
    logic [1:0] e_ctrl;
    logic [3:0] e_terc4;

    tmds_rx_channel #(
        .CTRL_RUN      (CTRL_RUN),
        .SEARCH_CYCLES (SEARCH_CYCLES),
        .LOSS_CYCLES   (LOSS_CYCLES)
    ) dut (
        .clk_pixel   (clk_pixel),
        .reset_n     (reset_n),
        .raw_in      (raw_in),
        .locked      (locked),
        .offset      (offset),
        .data        (data),
        .ctrl_valid  (ctrl_valid),
        .ctrl        (ctrl),
        .terc4_valid (terc4_valid),
        .terc4       (terc4)
    );

    always #5 clk_pixel = ~clk_pixel;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit is_tok(input logic [9:0] w);
        for (int i = 0; i < 4; i++) if (w == TOKS[i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [9:0] rand_data();
        logic [9:0] w;
        do w = 10'($urandom_range(0, 1023)); while (is_tok(w));
        return w;
    endfunction

    task automatic step(input logic rn, input logic [9:0] w);
        logic [19:0] comb;
        logic [9:0]  nsym;
        logic [7:0]  q;
        bit          tok;
        reset_n = rn;
        raw_in  = w;
        @(posedge clk_pixel);
        if (!rn) begin
            m_prev = '0; m_sym = '0; m_off = 0; m_run = 0; m_cyc = 0; m_blank = 0;
            m_miss = 0; m_locked = 0;
            e_data = '0; e_cv = 0; e_ctrl = '0; e_tv = 0; e_terc4 = '0;
        end else begin
            tok  = e_cv;
            comb = {w, m_prev};
            nsym = 10'(comb >> m_off);
            // Outputs show the symbol captured on the previous edge.
            q = m_sym[9] ? ~m_sym[7:0] : m_sym[7:0];
            e_data[0] = q[0];
            for (int i = 1; i < 8; i++)
                e_data[i] = m_sym[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
            e_cv = 0; e_ctrl = '0; e_tv = 0; e_terc4 = '0;
            for (int i = 0; i < 4; i++) if (m_sym == TOKS[i]) begin e_cv = 1; e_ctrl = 2'(i); end
            for (int i = 0; i < 16; i++) if (m_sym == T4[i]) begin e_tv = 1; e_terc4 = 4'(i); end
            if (!m_locked) begin
                if (m_blank > 0) begin m_run = 0; m_blank--; end
                else m_run = tok ? m_run + 1 : 0;
                m_cyc++;
                if (m_run == CTRL_RUN) begin
                    m_locked = 1; m_run = 0; m_cyc = 0; m_miss = 0;
                end else if (m_cyc == SEARCH_CYCLES) begin
                    m_off = (m_off + 1) % 10; m_run = 0; m_cyc = 0; m_blank = 2;
                end
            end else begin
                m_miss = tok ? 0 : m_miss + 1;
                if (m_miss == LOSS_CYCLES) begin
                    m_locked = 0; m_miss = 0; m_cyc = 0; m_run = 0;
                end
            end
            m_sym  = nsym;
            m_prev = w;
        end
        #1;
        chk("locked", locked, m_locked);
        chk("offset", offset, m_off);
        chk("data", data, e_data);
        chk("ctrl_valid", ctrl_valid, e_cv);
        chk("ctrl", ctrl, e_ctrl);
        chk("terc4_valid", terc4_valid, e_tv);
        chk("terc4", terc4, e_terc4);
    endtask

    initial begin
        logic [9:0] t, w3, w5, w;
        int lock_at, fall_at;
        t  = 10'h354;
        w3 = {t[6:0], t[9:7]};
        w5 = {t[4:0], t[9:5]};
        reset_n = 1'b0;
        raw_in  = '0;

        repeat (3) step(1'b0, 10'h000);
        chk("rst_locked", locked, 0);
        chk("rst_offset", offset, 0);
        chk("rst_data", data, 0);
        chk("rst_ctrl_valid", ctrl_valid, 0);

        // Aligned token stream: 8th token reaches the outputs after edge 10.
        lock_at = -1;
        for (int i = 1; i <= 40; i++) begin
            step(1'b1, t);
            if (locked && lock_at < 0) lock_at = i;
        end
        chk("aligned_lock_cycle", lock_at, 11);
        chk("aligned_offset", offset, 0);
        chk("aligned_ctrl", ctrl, 2'b00);

        step(1'b1, 10'h100);
        step(1'b1, 10'h2FF);
        step(1'b1, t);
        chk("data_100", data, 8'h00);
        chk("data_100_cv", ctrl_valid, 0);
        step(1'b1, t);
        chk("data_2ff", data, 8'hFE);
        chk("data_2ff_cv", ctrl_valid, 0);

        step(1'b1, 10'h29C);
        step(1'b1, 10'h2C3);
        step(1'b1, t);
        chk("terc4_0_valid", terc4_valid, 1);
        chk("terc4_0", terc4, 0);
        step(1'b1, t);
        chk("terc4_15_valid", terc4_valid, 1);
        chk("terc4_15", terc4, 15);
        step(1'b1, t);
        chk("terc4_tok_valid", terc4_valid, 0);
        chk("terc4_tok_cv", ctrl_valid, 1);

        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 3) == 0) w = TOKS[$urandom_range(0, 3)];
            else w = 10'($urandom_range(0, 1023));
            step(1'b1, w);
        end
        repeat (12) step(1'b1, t);
        chk("pre_loss_locked", locked, 1);

        // Loss: drops on the edge sampling the 128th consecutive non-token output.
        fall_at = -1;
        for (int i = 0; i <= 130; i++) begin
            step(1'b1, rand_data());
            if (!locked && fall_at < 0) fall_at = i;
        end
        chk("loss_fall_cycle", fall_at, 130);
        chk("loss_offset", offset, 0);

        lock_at = -1;
        for (int j = 0; j < 16; j++) begin
            step(1'b1, t);
            if (locked && lock_at < 0) lock_at = j;
        end
        chk("relock_cycle", lock_at, 10);
        chk("relock_offset", offset, 0);

        // Stream shifted by 3 bits.
        repeat (2) step(1'b0, 10'h000);
        lock_at = -1;
        for (int i = 1; i <= 230; i++) begin
            step(1'b1, w3);
            if (i == 63) chk("slip_before", offset, 0);
            if (i == 64) chk("slip_after", offset, 1);
            if (locked && lock_at < 0) lock_at = i;
        end
        chk("shift3_lock_cycle", lock_at, 3 * 64 + 10);
        chk("shift3_offset", offset, 3);

        // Stream shifted by 5 bits, then a single-cycle reset pulse.
        repeat (2) step(1'b0, 10'h000);
        lock_at = -1;
        for (int i = 1; i <= 360; i++) begin
            step(1'b1, w5);
            if (locked && lock_at < 0) lock_at = i;
        end
        chk("shift5_lock_cycle", lock_at, 5 * 64 + 10);
        chk("shift5_offset", offset, 5);
        step(1'b0, w5);
        chk("pulse_locked", locked, 0);
        chk("pulse_offset", offset, 0);
        chk("pulse_data", data, 0);
        chk("pulse_ctrl_valid", ctrl_valid, 0);
        chk("pulse_ctrl", ctrl, 0);
        chk("pulse_terc4_valid", terc4_valid, 0);
        chk("pulse_terc4", terc4, 0);
        repeat (20) step(1'b1, w5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
